// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit and the data memory:
// access-size encodings, FSM state encodings and alignment helpers.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'd0,
        SIZE_HALF    = 2'd1,
        SIZE_WORD    = 2'd2,
        SIZE_ILLEGAL = 2'd3
    } access_size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } mau_state_e;

    // Number of bytes touched by an access; 0 for the illegal encoding.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_bytes = 3'd1;
            SIZE_HALF: size_bytes = 3'd2;
            SIZE_WORD: size_bytes = 3'd4;
            default:   size_bytes = 3'd0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lsb);
        case (size)
            SIZE_HALF: is_misaligned = addr_lsb[0];
            SIZE_WORD: is_misaligned = (addr_lsb != 2'b00);
            default:   is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load extension: picks the low byte/half/word of the memory
// read data and sign- or zero-extends it to 32 bits.
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    always_comb begin
        result = data;
        case (size)
            SIZE_BYTE: result = {{24{~is_unsigned & data[7]}}, data[7:0]};
            SIZE_HALF: result = {{16{~is_unsigned & data[15]}}, data[15:0]};
            default:   result = data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between the execute stage and a data
// memory with registered reads; rejects misaligned, out-of-range and illegal-size ops.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter logic [31:0] BASE  = 32'h01000000,
    parameter logic [31:0] DEPTH = 32'h00100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_read_write,
    output logic [1:0]  mem_access_size,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_fault
);

    localparam logic [32:0] LAST_LEGAL = {1'b0, BASE} + {1'b0, DEPTH} - 33'd1;

    mau_state_e  state;
    mau_state_e  next_state;

    logic        lat_write;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [4:0]  lat_rd;
    logic [31:0] resp_data_q;
    logic        resp_fault_q;

    logic        handshake;
    logic        req_fault;
    logic [32:0] last_byte;
    logic [31:0] ext_result;

    // The last byte address is formed in 33 bits so a wrap past 2^32 lands above the legal range.
    assign last_byte = {1'b0, req_addr} + {30'd0, size_bytes(req_size)} - 33'd1;
    assign req_fault = (req_size == SIZE_ILLEGAL)
                    || is_misaligned(req_size, req_addr[1:0])
                    || (req_addr < BASE)
                    || (last_byte > LAST_LEGAL);

    assign handshake = req_valid & req_ready;

    load_extend u_load_extend (
        .data        (mem_data_out),
        .size        (lat_size),
        .is_unsigned (lat_unsigned),
        .result      (ext_result)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_write    <= 1'b0;
            lat_size     <= 2'd0;
            lat_unsigned <= 1'b0;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
            lat_rd       <= 5'd0;
            resp_data_q  <= 32'd0;
            resp_fault_q <= 1'b0;
        end else if (handshake) begin
            lat_write    <= req_write;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            lat_rd       <= req_rd;
            resp_data_q  <= 32'd0;
            resp_fault_q <= req_fault;
        end else if (state == CAPTURE) begin
            resp_data_q  <= ext_result;
        end
    end

    // Memory strobes come straight from the state register, so an async reset
    // during ACCESS removes the write strobe before the next edge.
    always_comb begin
        next_state      = state;
        req_ready       = 1'b0;
        mem_read_write  = 1'b0;
        mem_access_size = 2'd0;
        mem_address     = 32'd0;
        mem_data_in     = 32'd0;
        resp_valid      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = ~reset;
                if (req_valid && !reset) begin
                    next_state = req_fault ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_read_write  = lat_write;
                mem_access_size = lat_size;
                mem_address     = lat_addr;
                mem_data_in     = lat_wdata;
                next_state      = lat_write ? RESP : CAPTURE;
            end
            CAPTURE: begin
                mem_address = lat_addr;
                next_state  = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign resp_data  = resp_data_q;
    assign resp_rd    = lat_rd;
    assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-addressed data memory model
// that returns registered, LSB-aligned read data.
module tb_mem_access_unit;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_read_write;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_fault;

    int compared;
    int mismatched;
    int wr_count;

    logic [7:0] mem [logic [31:0]];

    mem_access_unit dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_rd          (req_rd),
        .mem_read_write  (mem_read_write),
        .mem_access_size (mem_access_size),
        .mem_address     (mem_address),
        .mem_data_in     (mem_data_in),
        .mem_data_out    (mem_data_out),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .resp_rd         (resp_rd),
        .resp_fault      (resp_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] memRead(input logic [31:0] a);
        logic [31:0] d;
        d = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (mem.exists(a + 32'(i))) d[8*i +: 8] = mem[a + 32'(i)];
        end
        return d;
    endfunction

    function automatic void memWrite(input logic [31:0] a, input logic [31:0] d, input logic [1:0] size);
        int n;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) mem[a + 32'(i)] = d[8*i +: 8];
    endfunction

    // Data memory: write on the edge when strobed, registered read of the presented address.
    always @(posedge clock) begin
        if (mem_read_write) begin
            memWrite(mem_address, mem_data_in, mem_access_size);
            wr_count = wr_count + 1;
        end
        mem_data_out <= memRead(mem_address);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one op, measures edges from the handshake edge to resp_valid,
    // optionally holds off resp_ready for hold cycles, then consumes the response.
    task automatic applyStimulus(input string tag, input logic w, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                                 input int hold, output int lat, output logic [31:0] data,
                                 output logic flt, output logic [4:0] rdo);
        int waits;
        waits = 0;
        while (!req_ready && waits < 20) begin
            @(posedge clock); #1;
            waits++;
        end
        if (!req_ready) checkOutput({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_rd       = rd;
        @(posedge clock); #1;
        req_valid    = 1'b0;
        req_write    = ~w;
        req_size     = ~sz;
        req_unsigned = ~uns;
        req_addr     = ~addr;
        req_wdata    = ~wd;
        req_rd       = ~rd;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clock); #1;
            lat++;
        end
        if (!resp_valid) checkOutput({tag, "_resp_timeout"}, 32'(resp_valid), 32'd1);
        data = resp_data;
        flt  = resp_fault;
        rdo  = resp_rd;
        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            checkOutput({tag, "_bp_valid"}, 32'(resp_valid), 32'd1);
            checkOutput({tag, "_bp_data"}, resp_data, data);
            checkOutput({tag, "_bp_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] data;
        logic        flt;
        logic [4:0]  rdo;
        int          wr_before;

        compared     = 0;
        mismatched   = 0;
        wr_count     = 0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        req_rd       = 5'd0;
        resp_ready   = 1'b0;

        memWrite(32'h01000000, 32'h55667788, 2'd2);
        memWrite(32'h01000004, 32'h99AABBCC, 2'd2);
        memWrite(32'h01000021, 32'h00000080, 2'd0);
        memWrite(32'h010FFFFC, 32'h12345678, 2'd2);
        memWrite(32'h01000040, 32'h11223344, 2'd2);

        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_mem_rw", 32'(mem_read_write), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        checkOutput("post_rst_req_ready", 32'(req_ready), 32'd1);

        applyStimulus("st_word", 1'b1, 2'd2, 1'b0, 32'h01000010, 32'hDEADBEEF, 5'd1, 0, lat, data, flt, rdo);
        checkOutput("st_word_lat", 32'(lat), 32'd2);
        checkOutput("st_word_fault", 32'(flt), 32'd0);
        checkOutput("st_word_data", data, 32'd0);
        checkOutput("st_word_mem", memRead(32'h01000010), 32'hDEADBEEF);

        applyStimulus("ld_word", 1'b0, 2'd2, 1'b0, 32'h01000010, 32'h0, 5'd5, 0, lat, data, flt, rdo);
        checkOutput("ld_word_lat", 32'(lat), 32'd3);
        checkOutput("ld_word_data", data, 32'hDEADBEEF);
        checkOutput("ld_word_rd", 32'(rdo), 32'd5);
        checkOutput("ld_word_fault", 32'(flt), 32'd0);

        applyStimulus("ld_sbyte", 1'b0, 2'd0, 1'b0, 32'h01000021, 32'h0, 5'd7, 0, lat, data, flt, rdo);
        checkOutput("ld_sbyte_data", data, 32'hFFFFFF80);
        applyStimulus("ld_ubyte", 1'b0, 2'd0, 1'b1, 32'h01000021, 32'h0, 5'd8, 0, lat, data, flt, rdo);
        checkOutput("ld_ubyte_data", data, 32'h00000080);
        applyStimulus("ld_shalf", 1'b0, 2'd1, 1'b0, 32'h01000012, 32'h0, 5'd9, 0, lat, data, flt, rdo);
        checkOutput("ld_shalf_data", data, 32'hFFFFDEAD);

        wr_before = wr_count;
        applyStimulus("st_mis", 1'b1, 2'd1, 1'b0, 32'h01000003, 32'h0000AAAA, 5'd2, 0, lat, data, flt, rdo);
        checkOutput("st_mis_lat", 32'(lat), 32'd1);
        checkOutput("st_mis_fault", 32'(flt), 32'd1);
        checkOutput("st_mis_data", data, 32'd0);
        checkOutput("st_mis_no_write", 32'(wr_count - wr_before), 32'd0);
        checkOutput("st_mis_mem0", memRead(32'h01000000), 32'h55667788);
        checkOutput("st_mis_mem4", memRead(32'h01000004), 32'h99AABBCC);

        applyStimulus("ld_below", 1'b0, 2'd2, 1'b0, 32'h00FFFFFC, 32'h0, 5'd3, 0, lat, data, flt, rdo);
        checkOutput("ld_below_fault", 32'(flt), 32'd1);
        checkOutput("ld_below_lat", 32'(lat), 32'd1);
        applyStimulus("ld_top", 1'b0, 2'd2, 1'b0, 32'h010FFFFC, 32'h0, 5'd4, 0, lat, data, flt, rdo);
        checkOutput("ld_top_fault", 32'(flt), 32'd0);
        checkOutput("ld_top_data", data, 32'h12345678);
        applyStimulus("ld_past", 1'b0, 2'd0, 1'b0, 32'h01100000, 32'h0, 5'd4, 0, lat, data, flt, rdo);
        checkOutput("ld_past_fault", 32'(flt), 32'd1);
        applyStimulus("ld_wrap", 1'b0, 2'd1, 1'b0, 32'hFFFFFFFE, 32'h0, 5'd6, 0, lat, data, flt, rdo);
        checkOutput("ld_wrap_fault", 32'(flt), 32'd1);
        checkOutput("ld_wrap_data", data, 32'd0);
        applyStimulus("ld_size3", 1'b0, 2'd3, 1'b0, 32'h01000010, 32'h0, 5'd6, 0, lat, data, flt, rdo);
        checkOutput("ld_size3_fault", 32'(flt), 32'd1);

        applyStimulus("bp", 1'b0, 2'd2, 1'b0, 32'h01000010, 32'h0, 5'd10, 5, lat, data, flt, rdo);
        checkOutput("bp_data", data, 32'hDEADBEEF);
        checkOutput("bp_idle_ready", 32'(req_ready), 32'd1);

        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h01000040;
        req_wdata = 32'hCAFEF00D;
        req_rd    = 5'd11;
        @(posedge clock); #1;
        req_valid = 1'b0;
        checkOutput("rst_acc_wr_high", 32'(mem_read_write), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("rst_acc_wr_low", 32'(mem_read_write), 32'd0);
        checkOutput("rst_acc_req_ready", 32'(req_ready), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        checkOutput("rst_acc_mem", memRead(32'h01000040), 32'h11223344);
        checkOutput("rst_acc_idle", 32'(req_ready), 32'd1);
        checkOutput("rst_acc_no_resp", 32'(resp_valid), 32'd0);
        @(posedge clock); #1;

        applyStimulus("ld_after_rst", 1'b0, 2'd2, 1'b0, 32'h01000040, 32'h0, 5'd12, 0, lat, data, flt, rdo);
        checkOutput("ld_after_rst_data", data, 32'h11223344);
        checkOutput("ld_after_rst_rd", 32'(rdo), 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
